mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max WAIT cycles before an access is abandoned.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- ctl_wb_in  in  2  WB controls from EX/MEM.
- ctl_mem_in  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- add_result_in  in  32  branch target.
- alu_result_in  in  32  data address or ALU result.
- rdata2_in  in  32  store data.
- zero_in  in  1  ALU zero.
- mux_out_in  in  5  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=write, 0=read.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  memory completes the access this cycle.
- dmem_rdata  in  32  load data, valid with dmem_ready.
- mem_stall  out  1  upstream stages hold.
- pc_src  out  1  branch taken.
- branch_target  out  32  equals add_result_in.
- ctl_wb_out  out  2  MEM/WB controls.
- read_data_out  out  32  MEM/WB load data.
- alu_result_out  out  32  MEM/WB ALU result.
- mux_5bit_result  out  5  MEM/WB destination register.
- mem_error  out  1  sticky fault flag.

Function
REQ-003 SHALL drive pc_src = ctl_mem_in[2] & zero_in combinationally, ungated by stall.
REQ-004 SHALL classify an access as legal when exactly one of MemRead/MemWrite is set and alu_result_in[1:0]==0.
REQ-005 SHALL implement FSM IDLE/WAIT.
REQ-006 In IDLE with a legal access, SHALL assert dmem_req, with dmem_we=MemWrite, dmem_addr=alu_result_in and dmem_wdata=rdata2_in.
REQ-007 In IDLE, if dmem_ready=1 in that same cycle, SHALL complete with zero stall; otherwise SHALL set mem_stall=1 and enter WAIT.
REQ-008 In WAIT, SHALL hold dmem_req, dmem_we, dmem_addr and dmem_wdata from inputs that upstream holds stable.
REQ-009 In WAIT, SHALL drive mem_stall = ~dmem_ready.
REQ-010 In WAIT, on dmem_ready=1 SHALL complete and return to IDLE.
REQ-011 SHALL count WAIT cycles; when the count reaches TIMEOUT_CYCLES without dmem_ready, SHALL drop dmem_req, set mem_error, load a bubble, release stall and return to IDLE.
REQ-012 On completion edge, MEM/WB SHALL load: ctl_wb_in, dmem_rdata (loads; zero for stores), alu_result_in, mux_out_in.
REQ-013 With no access, MEM/WB SHALL load inputs with read_data_out=0, every cycle.
REQ-014 Each cycle with mem_stall=1, MEM/WB SHALL load a bubble: ctl_wb_out=0; other fields don't-care.
REQ-015 On an illegal access (both Mem bits set, or misaligned), SHALL issue no request, set mem_error and load a bubble; no stall.
REQ-016 mem_error SHALL remain set until reset.
REQ-017 Total latency input-to-MEM/WB SHALL be 1 cycle plus stall cycles.
REQ-018 dmem_ready while dmem_req=0 SHALL be ignored.

Reset
REQ-019 Reset SHALL force IDLE, timeout count 0, mem_error=0 and all MEM/WB outputs 0.
REQ-020 Reset during WAIT SHALL drop dmem_req immediately (asynchronous), with no MEM/WB load.
REQ-021 After reset, dmem_req, mem_stall=0 until a legal access is presented.

Structure
REQ-022 Shared package mips_pkg SHALL hold the ctl_mem bit indices (BRANCH=2, MEMREAD=1, MEMWRITE=0) and the FSM state enum.
REQ-023 MEM/WB storage SHALL be sub-module mem_wb_pipeline_register, with a bubble input; FSM, counter and branch logic SHALL be in the top level.

Verification
REQ-024 Zero-wait load: MemRead, addr 0x10, dmem_ready=1 same cycle, rdata 0xDEADBEEF -> no stall; next edge read_data_out=0xDEADBEEF.
REQ-025 3-wait store: MemWrite, addr 0x20, wdata 0x1234, ready on 4th cycle -> mem_stall high 3 cycles, dmem_we=1, 3 bubbles (ctl_wb_out=0), then ctl_wb_out=ctl_wb_in.
REQ-026 Timeout: TIMEOUT_CYCLES=4, never ready -> dmem_req dropped after 4 WAIT cycles, mem_error=1, bubble, stall released.
REQ-027 Misaligned: MemRead, addr 0x22 -> no dmem_req, mem_error=1, ctl_wb_out=0, no stall.
REQ-028 Branch: ctl_mem_in=3'b100 with zero_in=1 -> pc_src=1, branch_target=add_result_in; with zero_in=0 -> pc_src=0.
REQ-029 Reset mid-WAIT -> dmem_req=0 and all outputs 0 immediately; next legal load completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ctl_mem bit positions, MEM-stage FSM
// states and the access legality rule.
package mips_pkg;

    localparam int CTL_BRANCH   = 2;
    localparam int CTL_MEMREAD  = 1;
    localparam int CTL_MEMWRITE = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    // A data access is legal when exactly one of read/write is requested and
    // the address is word aligned.
    function automatic logic access_legal(input logic [2:0] ctl_mem,
                                          input logic [1:0] addr_lo);
        return (ctl_mem[CTL_MEMREAD] ^ ctl_mem[CTL_MEMWRITE]) && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_pipeline_register.sv
// MEM/WB pipeline register. Loads every cycle; a bubble clears the WB
// controls so nothing downstream commits.
import mips_pkg::*;

module mem_wb_pipeline_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  logic [1:0]  ctl_wb_in,
    input  logic [31:0] read_data_in,
    input  logic [31:0] alu_result_in,
    input  logic [4:0]  mux_out_in,
    output logic [1:0]  ctl_wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  mux_5bit_result
);

    // Register all fields; only the WB controls are forced on a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_wb_out      <= '0;
            read_data_out   <= '0;
            alu_result_out  <= '0;
            mux_5bit_result <= '0;
        end else begin
            ctl_wb_out      <= bubble ? 2'b00 : ctl_wb_in;
            read_data_out   <= read_data_in;
            alu_result_out  <= alu_result_in;
            mux_5bit_result <= mux_out_in;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory handshake, stalls upstream while an
// access is outstanding, abandons it after TIMEOUT_CYCLES wait cycles and
// resolves the branch decision.
import mips_pkg::*;

module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctl_wb_in,
    input  logic [2:0]  ctl_mem_in,
    input  logic [31:0] add_result_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rdata2_in,
    input  logic        zero_in,
    input  logic [4:0]  mux_out_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic [1:0]  ctl_wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  mux_5bit_result,
    output logic        mem_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic access, legal, illegal, timed_out;
    logic req, stall, bubble, err_set;
    logic [31:0] load_data;

    assign access    = ctl_mem_in[CTL_MEMREAD] | ctl_mem_in[CTL_MEMWRITE];
    assign legal     = access_legal(ctl_mem_in, alu_result_in[1:0]);
    assign illegal   = access & ~legal;
    assign timed_out = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    assign pc_src        = ctl_mem_in[CTL_BRANCH] & zero_in;
    assign branch_target = add_result_in;

    // Reset is combined in so an outstanding request drops the instant reset
    // rises, even while upstream still presents the access.
    assign dmem_req   = req & ~reset;
    assign mem_stall  = stall & ~reset;
    assign dmem_we    = dmem_req & ctl_mem_in[CTL_MEMWRITE];
    assign dmem_addr  = alu_result_in;
    assign dmem_wdata = rdata2_in;

    // Load data is captured only on a completing read; all else writes zero.
    assign load_data = (req && dmem_ready && ctl_mem_in[CTL_MEMREAD]) ? dmem_rdata : 32'd0;

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && next_state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (err_set)
                mem_error <= 1'b1;
        end
    end

    // Next state and handshake/stall/bubble decisions. The timeout cycle
    // itself releases the stall so upstream moves past the abandoned access
    // rather than re-issuing it from IDLE.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        stall      = 1'b0;
        bubble     = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (illegal) begin
                    bubble  = 1'b1;
                    err_set = 1'b1;
                end else if (legal) begin
                    req = 1'b1;
                    if (!dmem_ready) begin
                        stall      = 1'b1;
                        bubble     = 1'b1;
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (timed_out) begin
                    bubble     = 1'b1;
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    req = 1'b1;
                    if (dmem_ready) begin
                        next_state = S_IDLE;
                    end else begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    mem_wb_pipeline_register u_mem_wb (
        .clk             (clk),
        .reset           (reset),
        .bubble          (bubble),
        .ctl_wb_in       (ctl_wb_in),
        .read_data_in    (load_data),
        .alu_result_in   (alu_result_in),
        .mux_out_in      (mux_out_in),
        .ctl_wb_out      (ctl_wb_out),
        .read_data_out   (read_data_out),
        .alu_result_out  (alu_result_out),
        .mux_5bit_result (mux_5bit_result)
    );

endmodule
